acia_6502: RTL and testbench
============================

// Module: acia_6502
// PURPOSE
//  Memory-mapped 8N1 UART for the 6502 system, decoded on page $2xxx (CPU_AB[15:12]==4'h2).
//  Drives the board TX pin and samples the RX pin.
//  Presents a 4-register window to the CPU bus and feeds the CPU_DI read mux with
//  registered read data (same one-cycle read latency as ROM/SRAM). Raises a level IRQ.
// PARAMETERS
//  OVS_DIV    13  clk cycles per 16x oversample tick (4 MHz / (16*19200) ~= 13); legal 1..255
//  OVS_RATE   16  oversample ticks per bit; fixed, not overridable by users
// PORTS
//  clk      in   1  CPU clock; all logic on posedge
//  reset    in   1  synchronous, active-low reset
//  cs       in   1  chip select, high when CPU_AB[15:12]==4'h2
//  we       in   1  CPU_WE, high = write cycle
//  rs       in   2  register select = CPU_AB[1:0]
//  din      in   8  CPU_DO write data
//  dout     out  8  read data, registered, valid the cycle after a cs&~we address cycle
//  irq      out  1  level interrupt request, high-true; system inverts/ORs into CPU_IRQ
//  rx       in   1  serial input, asynchronous, idle high
//  tx       out  1  serial output, idle high
// BEHAVIOUR
//  Reset (reset==0 at posedge): tx=1, dout=8'h00, irq=0.
//   Also: rxf=0, ovr=0, ferr=0, txe=1, ctrl=8'h00, both FSMs IDLE, tick divider=0.
//  Register map:
//   rs=0 R STATUS {rxf,txe,ovr,ferr,2'b0,tx_busy,irq}; W CTRL, only [7]=rx_ie and [6]=tx_ie kept
//   rs=1 R RXDATA, clears rxf/ovr;     W TXDATA, loads holding reg
//   rs=2 R CTRL readback;              W ignored
//   rs=3 R 8'h00;                      W ignored
//  Read timing: dout <= mux(rs) on every posedge where cs&~we; otherwise dout holds.
//  Read side effect happens in that same cycle.
//  irq = (rx_ie & rxf) | (tx_ie & txe); registered, updates 1 cycle after the flags.
//  Tick: free-running divider pulses `tick` for 1 clk every OVS_DIV clks; shared by RX and TX.
//  TX: 8-bit holding reg + 10-bit shifter {stop,data,start}, LSB first.
//   Write TXDATA with txe=1: hold<=din, txe<=0.
//   Write TXDATA with txe=0: ignored, no flag set.
//   FSM IDLE->SHIFT when hold full: shifter loads from hold, txe<=1, tx_busy<=1.
//   SHIFT: each bit lasts 16 ticks; after 10 bits ->IDLE, or straight to SHIFT if hold full
//   (back-to-back frames, no gap). tx_busy=0 only in IDLE.
//  RX: rx through 2-FF synchroniser (set to 1 on reset).
//   FSM IDLE: falling edge of synced rx -> START with tick counter cleared.
//   START: on 8th tick resample; if 1 -> IDLE (glitch rejected, no flags).
//   DATA: sample at tick 16 of each bit (mid-bit), 8 bits LSB first.
//   STOP: sample at mid-bit; ferr<=~sample; byte stored in RXDATA even if ferr; -> IDLE.
//   Store: rxf<=1; if rxf already 1 then ovr<=1 and RXDATA is overwritten by the new byte.
//   Store and RXDATA read in same cycle: store wins (rxf stays 1, ovr not set).
//   dout returns the old byte.
//  Reset asserted mid-frame aborts both FSMs immediately. tx returns to 1 the next cycle.
//  A partially received byte is discarded.
//  Counter widths: divider $clog2(OVS_DIV+1), tick count 4 bits, bit index 4 bits;
//  all wrap modulo their own limits, never free-overflow.
// STRUCTURE
//  Package acia_pkg:
//   register offsets (ACIA_STATUS=0, ACIA_DATA=1, ACIA_CTRL=2)
//   STATUS/CTRL bit positions
//   TX/RX FSM state enums
//  Sub-module acia_rx (sync + RX FSM + shift reg):
//   outputs rx_byte[7:0], rx_stb (1-clk), rx_ferr
//  TX path, divider and register file stay in acia_6502.
// TESTING (sim with OVS_DIV=2, so 1 bit = 32 clk)
//  1 Reset, then read rs=0 -> dout=8'h40 next cycle (txe=1); tx=1; irq=0.
//  2 Write $55 to rs=1 -> txe=0 for 1 cycle, then tx low for 32 clk.
//    Then 1,0,1,0,1,0,1,0 at 32 clk each, then stop=1; status.txe=1 once loaded.
//  3 Write $01 then $02 back-to-back, waiting only for txe=1 -> two frames with no idle gap;
//    third write while txe=0 is dropped.
//  4 Drive rx frame $A5 -> rxf=1; read rs=1 -> dout=$A5 and rxf=0 next cycle.
//    With ctrl=$80: irq high while rxf=1, low 1 cycle after read.
//  5 Two frames $11,$22 without reading -> STATUS shows ovr=1; RXDATA=$22.
//    Frame with stop bit 0 -> ferr=1, byte stored.
//  6 16-clk low glitch on rx -> no rxf.
//    Assert reset mid-TX-frame -> tx=1 next cycle, txe=1, irq=0.

Source files
------------

// File: rtl/acia_pkg.sv
// Register map, status/control bit positions and FSM encodings shared by the
// 6502 ACIA top level and its receiver.
package acia_pkg;

  // Oversample ticks per serial bit; fixed by the framing logic.
  localparam int OVS_RATE = 16;
  localparam logic [3:0] TICK_LAST = 4'(OVS_RATE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVS_RATE / 2 - 1);

  localparam logic [1:0] ACIA_STATUS = 2'd0;
  localparam logic [1:0] ACIA_DATA   = 2'd1;
  localparam logic [1:0] ACIA_CTRL   = 2'd2;

  localparam int ST_RXF  = 7;
  localparam int ST_TXE  = 6;
  localparam int ST_OVR  = 5;
  localparam int ST_FERR = 4;
  localparam int ST_BUSY = 1;
  localparam int ST_IRQ  = 0;

  localparam int CTRL_RX_IE = 7;
  localparam int CTRL_TX_IE = 6;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [7:0] pack_status(input logic rxf, input logic txe,
                                             input logic ovr, input logic ferr,
                                             input logic busy, input logic irq);
    logic [7:0] s;
    s          = 8'h00;
    s[ST_RXF]  = rxf;
    s[ST_TXE]  = txe;
    s[ST_OVR]  = ovr;
    s[ST_FERR] = ferr;
    s[ST_BUSY] = busy;
    s[ST_IRQ]  = irq;
    return s;
  endfunction

endpackage

// File: rtl/acia_rx.sv
// 8N1 receiver: two-flop synchroniser, start-bit qualification, mid-bit
// sampling and a one-clock strobe carrying the byte and framing error.
module acia_rx
  import acia_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_stb,
  output logic       o_rx_ferr
);

  rx_state_t  r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_rx_d;
  logic [3:0] r_tick_cnt;
  logic [3:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic       r_stb;
  logic       r_ferr;
  logic       w_fall;

  assign w_fall    = r_rx_d & ~r_sync2;
  assign o_rx_byte = r_byte;
  assign o_rx_stb  = r_stb;
  assign o_rx_ferr = r_ferr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_state    <= RX_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 4'd0;
      r_shift    <= 8'h00;
      r_byte     <= 8'h00;
      r_stb      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      r_stb   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state    <= RX_START;
            r_tick_cnt <= 4'd0;
          end
        end
        RX_START: begin
          if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            // Half a bit in: a line already back high was only a glitch.
            if (r_tick_cnt == TICK_MID) begin
              r_tick_cnt <= 4'd0;
              r_bit_idx  <= 4'd0;
              r_state    <= r_sync2 ? RX_IDLE : RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == TICK_LAST) begin
              r_shift   <= {r_sync2, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 4'd1;
              if (r_bit_idx == 4'd7) begin
                r_state <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == TICK_LAST) begin
              r_byte  <= r_shift;
              r_ferr  <= ~r_sync2;
              r_stb   <= 1'b1;
              r_state <= RX_IDLE;
            end
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acia_6502.sv
// Memory-mapped 8N1 UART for the 6502 bus: register window with registered
// read data, shared oversample divider, transmitter and level IRQ.
module acia_6502
  import acia_pkg::*;
#(
  parameter int OVS_DIV = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       rx,
  output logic       tx
);

  localparam int DIV_W = $clog2(OVS_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  logic       r_rx_ie;
  logic       r_tx_ie;
  logic       r_rxf;
  logic       r_ovr;
  logic       r_ferr;
  logic [7:0] r_rxdata;
  logic [7:0] r_dout;
  logic       r_irq;

  tx_state_t  r_tx_state;
  logic [7:0] r_tx_hold;
  logic       r_txe;
  logic [9:0] r_tx_shift;
  logic [3:0] r_tx_tick;
  logic [3:0] r_tx_bit;
  logic       r_tx_busy;

  logic       w_rd;
  logic       w_rd_data;
  logic       w_wr_ctrl;
  logic       w_wr_data;
  logic [7:0] w_status;
  logic [7:0] w_rd_mux;
  logic [7:0] w_rx_byte;
  logic       w_rx_stb;
  logic       w_rx_ferr;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_rd      = cs & ~we;
  assign w_rd_data = w_rd & (rs == ACIA_DATA);
  assign w_wr_ctrl = cs & we & (rs == ACIA_STATUS);
  assign w_wr_data = cs & we & (rs == ACIA_DATA);
  assign w_status  = pack_status(r_rxf, r_txe, r_ovr, r_ferr, r_tx_busy, r_irq);

  assign dout = r_dout;
  assign irq  = r_irq;
  assign tx   = r_tx_shift[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  acia_rx u_rx (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (w_tick),
    .i_rx      (rx),
    .o_rx_byte (w_rx_byte),
    .o_rx_stb  (w_rx_stb),
    .o_rx_ferr (w_rx_ferr)
  );

  always_comb begin
    w_rd_mux = 8'h00;
    case (rs)
      ACIA_STATUS: w_rd_mux = w_status;
      ACIA_DATA:   w_rd_mux = r_rxdata;
      ACIA_CTRL:   w_rd_mux = {r_rx_ie, r_tx_ie, 6'b000000};
      default:     w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dout   <= 8'h00;
      r_rx_ie  <= 1'b0;
      r_tx_ie  <= 1'b0;
      r_rxf    <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      r_rxdata <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      if (w_rd) begin
        r_dout <= w_rd_mux;
      end
      if (w_wr_ctrl) begin
        r_rx_ie <= din[CTRL_RX_IE];
        r_tx_ie <= din[CTRL_TX_IE];
      end
      // A new byte beats a simultaneous RXDATA read; the CPU still gets the old one.
      if (w_rx_stb) begin
        r_rxdata <= w_rx_byte;
        r_rxf    <= 1'b1;
        r_ferr   <= w_rx_ferr;
        if (w_rd_data) begin
          r_ovr <= 1'b0;
        end else if (r_rxf) begin
          r_ovr <= 1'b1;
        end
      end else if (w_rd_data) begin
        r_rxf <= 1'b0;
        r_ovr <= 1'b0;
      end
      r_irq <= (r_rx_ie & r_rxf) | (r_tx_ie & r_txe);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_hold  <= 8'h00;
      r_txe      <= 1'b1;
      r_tx_shift <= '1;
      r_tx_tick  <= 4'd0;
      r_tx_bit   <= 4'd0;
      r_tx_busy  <= 1'b0;
    end else begin
      // Writes only land in an empty holding register; otherwise they are dropped.
      if (w_wr_data && r_txe) begin
        r_tx_hold <= din;
        r_txe     <= 1'b0;
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (!r_txe) begin
            r_tx_shift <= {1'b1, r_tx_hold, 1'b0};
            r_txe      <= 1'b1;
            r_tx_busy  <= 1'b1;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 4'd0;
            r_tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (w_tick) begin
            r_tx_tick <= r_tx_tick + 4'd1;
            if (r_tx_tick == TICK_LAST) begin
              if (r_tx_bit != 4'd9) begin
                r_tx_bit   <= r_tx_bit + 4'd1;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
              end else if (!r_txe) begin
                // Next byte already waiting: start it with no idle gap.
                r_tx_shift <= {1'b1, r_tx_hold, 1'b0};
                r_txe      <= 1'b1;
                r_tx_bit   <= 4'd0;
              end else begin
                r_tx_shift <= '1;
                r_tx_busy  <= 1'b0;
                r_tx_state <= TX_IDLE;
              end
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acia_6502.sv
// Directed bench for acia_6502 with OVS_DIV=2 (one serial bit = 32 clocks).
module tb_acia_6502;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       rx;
  logic       tx;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       cs;
    logic       we;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[16];

  acia_6502 #(.OVS_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .rs    (rs),
    .din   (din),
    .dout  (dout),
    .irq   (irq),
    .rx    (rx),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cs = 1'b0; we = 1'b0; rx = 1'b1; reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; rs = a;
    @(negedge clk);
    d = dout;
    cs = 1'b0;
  endtask

  // Samples tx at bit centres; first_wait positions the first sample mid start bit.
  task automatic tx_bits(input int first_wait, input int nbits, output logic [9:0] bits);
    bits = '1;
    repeat (first_wait) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < nbits; i++) begin
      repeat (32) @(negedge clk);
      bits[i] = tx;
    end
  endtask

  task automatic count_high(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (tx !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    while (tx === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_low(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (32) @(negedge clk);
    end
    rx = stop_bit;
    repeat (32) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    logic [9:0] bits;
    int         n;

    n_tests = 0;
    n_fail  = 0;
    cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00; rx = 1'b1; reset = 1'b0;

    //          cs    we    rs     din    dout   irq
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h40, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 8'h40, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'hC0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h41, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 8'h12, 8'h41, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'hC0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 8'h34, 8'hC0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 8'h7F, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h40, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 2'd0, 8'h80, 8'h40, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h80, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h40, 1'b0};

    // Reset state and register window.
    do_reset();
    check("reset tx", 16'(tx), 16'h1);
    check("reset irq", 16'(irq), 16'h0);
    check("reset dout", 16'(dout), 16'h00);
    for (int i = 0; i < 16; i++) begin
      cs = vecs[i].cs; we = vecs[i].we; rs = vecs[i].rs; din = vecs[i].din;
      @(negedge clk);
      check($sformatf("vec%0d dout", i), 16'(dout), 16'(vecs[i].exp_dout));
      check($sformatf("vec%0d irq", i), 16'(irq), 16'(vecs[i].exp_irq));
    end
    cs = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame $55.
    cpu_write(2'd1, 8'h55);
    cpu_read(2'd0, s);
    check("tx55 status txe=0", 16'(s), 16'h00);
    check("tx55 start low", 16'(tx), 16'h0);
    cpu_read(2'd0, s);
    check("tx55 status loaded", 16'(s), 16'h42);
    tx_bits(15, 10, bits);
    check("tx55 frame", 16'(bits), 16'h2AA);
    repeat (24) @(negedge clk);
    cpu_read(2'd0, s);
    check("tx55 status idle", 16'(s), 16'h40);
    check("tx55 line idle", 16'(tx), 16'h1);

    // Back-to-back frames $01,$02; third write dropped.
    cpu_write(2'd1, 8'h01);
    cpu_read(2'd0, s);
    check("b2b txe after write", 16'(s[6]), 16'h0);
    cpu_read(2'd0, s);
    check("b2b status loaded", 16'(s), 16'h42);
    cpu_write(2'd1, 8'h02);
    cpu_read(2'd0, s);
    check("b2b hold full", 16'(s), 16'h02);
    cpu_write(2'd1, 8'hFF);
    tx_bits(12, 9, bits);
    check("b2b frame1 start+data", 16'(bits[8:0]), 16'h002);
    count_high(n);
    check("b2b stop length", 16'(n), 16'd32);
    tx_bits(16, 10, bits);
    check("b2b frame2", 16'(bits), 16'h204);
    count_low(400, n);
    check("b2b no third frame", 16'(n), 16'd0);
    cpu_read(2'd0, s);
    check("b2b status idle", 16'(s), 16'h40);

    // Receive $A5 with rx interrupt enabled (ctrl still $80).
    rx_frame(8'hA5, 1'b1);
    check("rxA5 irq", 16'(irq), 16'h1);
    cpu_read(2'd0, s);
    check("rxA5 status", 16'(s), 16'hC1);
    cpu_read(2'd1, s);
    check("rxA5 data", 16'(s), 16'hA5);
    check("rxA5 irq same cycle", 16'(irq), 16'h1);
    @(negedge clk);
    check("rxA5 irq dropped", 16'(irq), 16'h0);
    cpu_read(2'd0, s);
    check("rxA5 status cleared", 16'(s), 16'h40);

    // Overrun, then framing error.
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    cpu_read(2'd0, s);
    check("ovr status", 16'(s), 16'hE1);
    cpu_read(2'd1, s);
    check("ovr data", 16'(s), 16'h22);
    cpu_read(2'd0, s);
    check("ovr cleared", 16'(s), 16'h41);
    rx_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    cpu_read(2'd0, s);
    check("ferr status", 16'(s), 16'hD1);
    cpu_read(2'd1, s);
    check("ferr data", 16'(s), 16'h3C);

    // 16-clock glitch, launched so the start-bit sample lands just after it ends.
    do_reset();
    repeat (9) @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    cpu_read(2'd0, s);
    check("glitch status", 16'(s), 16'h40);

    // Reset in the middle of a transmit frame.
    cpu_write(2'd0, 8'hC0);
    cpu_write(2'd1, 8'h00);
    repeat (100) @(negedge clk);
    check("midtx line low", 16'(tx), 16'h0);
    check("midtx irq", 16'(irq), 16'h1);
    reset = 1'b0;
    @(negedge clk);
    check("midtx reset tx", 16'(tx), 16'h1);
    check("midtx reset irq", 16'(irq), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_low(400, n);
    check("midtx frame aborted", 16'(n), 16'd0);
    cpu_read(2'd0, s);
    check("midtx status", 16'(s), 16'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
